// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall arbitration and exception/ERET flush sequencing for the
// five-stage core. A flush raised while the data-SRAM access in MEM is still
// outstanding is deferred (DRAIN) until that access completes.
//
// Optional build macro: PIPE_CTRL_PERF_EN enables saturating stall-cycle and
// flush counters; without it both perf outputs are tied to zero.
//
// state | meaning
// ------+--------------------------------------------------------------
// RUN   | normal operation; stall arbitration, immediate flushes
// DRAIN | exception latched, holding pipe until MEM access completes
module pipe_ctrl #(
    parameter logic [31:0] EXC_ENTRY = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE = 32'h0000000E
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_from_if,
    input  logic        stallreq_from_id,
    input  logic        stallreq_from_ex,
    input  logic        stallreq_from_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count
);

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_IF   = 6'b000011;
    localparam logic [5:0] STALL_NONE = 6'b000000;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] exc_q;
    logic [31:0] pc_q;

    logic        exc_present;
    logic [31:0] exc_target;
    logic        defer_exc;

    assign exc_present = (excepttype_i != 32'd0);
    assign exc_target  = (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_ENTRY;
    assign defer_exc   = (state_q == RUN) && exc_present && stallreq_from_mem;

    // State register plus capture of the deferred exception and its target
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            exc_q   <= 32'd0;
            pc_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            if (defer_exc) begin
                exc_q <= excepttype_i;
                pc_q  <= exc_target;
            end
        end
    end

    // Next-state: enter DRAIN on a deferred exception, leave once MEM frees up
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (exc_present && stallreq_from_mem) state_d = DRAIN;
            DRAIN:   if (!stallreq_from_mem)               state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Outputs: combinational from inputs and state, all forced low in reset
    always_comb begin
        stall  = STALL_NONE;
        flush  = 1'b0;
        new_pc = 32'd0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (exc_present) begin
                        if (stallreq_from_mem) begin
                            stall = STALL_MEM;
                        end else begin
                            flush  = 1'b1;
                            new_pc = exc_target;
                        end
                    end else if (stallreq_from_mem) begin
                        stall = STALL_MEM;
                    end else if (stallreq_from_ex) begin
                        stall = STALL_EX;
                    end else if (stallreq_from_id) begin
                        stall = STALL_ID;
                    end else if (stallreq_from_if) begin
                        stall = STALL_IF;
                    end
                end
                DRAIN: begin
                    // exc_q is always nonzero here; the check guards against
                    // flushing on a capture that never happened
                    if (stallreq_from_mem) begin
                        stall = STALL_MEM;
                    end else if (exc_q != 32'd0) begin
                        flush  = 1'b1;
                        new_pc = pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    // Saturating event counters, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            if ((stall != STALL_NONE) && (stall_cnt_q != 32'hFFFFFFFF))
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush && (flush_cnt_q != 32'hFFFFFFFF))
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flush_count  = flush_cnt_q;
`else
    assign perf_stall_cycles = 32'd0;
    assign perf_flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with a queue-based scoreboard: the
// stimulus process pushes the expected response of each cycle and a monitor
// compares it against the DUT on the falling edge.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_if = 1'b0, req_id = 1'b0, req_ex = 1'b0, req_mem = 1'b0;
    logic [31:0] exc = 32'd0;
    logic [31:0] epc = 32'd0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_flush_count;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string       name;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];

    pipe_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_if  (req_if),
        .stallreq_from_id  (req_id),
        .stallreq_from_ex  (req_ex),
        .stallreq_from_mem (req_mem),
        .excepttype_i      (exc),
        .cp0_epc_i         (epc),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, required %h", nm, act, req);
    endtask

    // One cycle of stimulus: drive after the rising edge, queue the expectation
    task automatic step(input string nm, input logic r,
                        input logic i_if, input logic i_id, input logic i_ex, input logic i_mem,
                        input logic [31:0] i_exc, input logic [31:0] i_epc,
                        input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; req_if = i_if; req_id = i_id; req_ex = i_ex; req_mem = i_mem;
        exc = i_exc; epc = i_epc;
        e.name = nm; e.stall = e_stall; e.flush = e_flush; e.pc = e_pc;
        sb_q.push_back(e);
    endtask

    // Monitor: outputs are combinational, so every driven cycle presents one
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk({e.name, ".stall"}, {26'd0, stall},  {26'd0, e.stall});
            chk({e.name, ".flush"}, {31'd0, flush},  {31'd0, e.flush});
            chk({e.name, ".new_pc"}, new_pc, e.pc);
        end
    end

    initial begin
        //    name          rst if id ex mem exc           epc           stall      fl pc
        step("rst0",        1, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0);
        step("rst1_force",  1, 1, 1, 1, 1, 32'h1,        32'h1234,     6'b000000, 0, 32'h0);
        step("idle",        0, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0);
        step("id_ex",       0, 0, 1, 1, 0, 32'h0,        32'h0,        6'b001111, 0, 32'h0);
        step("id",          0, 0, 1, 0, 0, 32'h0,        32'h0,        6'b000111, 0, 32'h0);
        step("if",          0, 1, 0, 0, 0, 32'h0,        32'h0,        6'b000011, 0, 32'h0);
        step("mem_if",      0, 1, 0, 0, 1, 32'h0,        32'h0,        6'b011111, 0, 32'h0);
        step("exc_imm",     0, 0, 1, 1, 0, 32'h1,        32'h0,        6'b000000, 1, 32'hBFC00380);
        step("eret_imm",    0, 0, 0, 0, 0, 32'h0E,       32'h80001234, 6'b000000, 1, 32'h80001234);
        step("idle2",       0, 0, 0, 0, 0, 32'h0,        32'h80001234, 6'b000000, 0, 32'h0);
        // deferred ERET: latched target must survive type/EPC changes
        step("def_enter",   0, 0, 0, 0, 1, 32'h0E,       32'h80005678, 6'b011111, 0, 32'h0);
        step("drain1",      0, 1, 0, 1, 1, 32'h1,        32'hDEADBEEF, 6'b011111, 0, 32'h0);
        step("drain2",      0, 0, 1, 0, 1, 32'h0,        32'h0,        6'b011111, 0, 32'h0);
        step("drain_flush", 0, 0, 1, 0, 0, 32'h5,        32'h0,        6'b000000, 1, 32'h80005678);
        step("post_drain",  0, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0);
        // reset in the middle of DRAIN must drop the pending flush
        step("rd_enter",    0, 0, 0, 0, 1, 32'h1,        32'h0,        6'b011111, 0, 32'h0);
        step("rd_reset",    1, 0, 0, 0, 1, 32'h0,        32'h0,        6'b000000, 0, 32'h0);
        step("rd_noflush",  0, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0);
        // five stall cycles and two flushes since the last reset
        step("pf_mem",      0, 0, 0, 0, 1, 32'h0,        32'h0,        6'b011111, 0, 32'h0);
        step("pf_if",       0, 1, 0, 0, 0, 32'h0,        32'h0,        6'b000011, 0, 32'h0);
        step("pf_id",       0, 0, 1, 0, 0, 32'h0,        32'h0,        6'b000111, 0, 32'h0);
        step("pf_def",      0, 0, 0, 0, 1, 32'h3,        32'h0,        6'b011111, 0, 32'h0);
        step("pf_drain",    0, 0, 0, 0, 1, 32'h0,        32'h0,        6'b011111, 0, 32'h0);
        step("pf_flush1",   0, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 1, 32'hBFC00380);
        step("pf_flush2",   0, 0, 0, 0, 0, 32'h0E,       32'h80000040, 6'b000000, 1, 32'h80000040);
        step("pf_idle",     0, 0, 0, 0, 0, 32'h0,        32'h0,        6'b000000, 0, 32'h0);

        repeat (3) @(negedge clk);
        total++;
        if (sb_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb_q.size());

`ifdef PIPE_CTRL_PERF_EN
        chk("perf_stall_cycles", perf_stall_cycles, 32'd5);
        chk("perf_flush_count",  perf_flush_count,  32'd2);
`else
        chk("perf_stall_cycles", perf_stall_cycles, 32'd0);
        chk("perf_flush_count",  perf_flush_count,  32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
